// File: rtl/hilo_div_unit_if.sv
// rtl/hilo_div_unit_if.sv - E-stage bundle between the pipeline and the HI/LO divide unit
// Purpose: groups the decoder controls, operands, stall/done status and HI/LO read data.
// Ports (signals):
//   flush, div_i, hassign_i, hilo_en_i[1:0], hilo_mf_i[1:0] : pipeline controls
//   a_i, b_i [WIDTH], prod_i [2*WIDTH]                       : operands / product
//   stall_o, div_done_o, hilo_rdata_o, hi_o, lo_o            : unit status and data
// Modports: master = pipeline side, slave = HI/LO divide unit.
interface hilo_div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 flush;
  logic                 div_i;
  logic                 hassign_i;
  logic [1:0]           hilo_en_i;
  logic [1:0]           hilo_mf_i;
  logic [WIDTH-1:0]     a_i;
  logic [WIDTH-1:0]     b_i;
  logic [2*WIDTH-1:0]   prod_i;
  logic                 stall_o;
  logic                 div_done_o;
  logic [WIDTH-1:0]     hilo_rdata_o;
  logic [WIDTH-1:0]     hi_o;
  logic [WIDTH-1:0]     lo_o;

  modport master (
    output flush, div_i, hassign_i, hilo_en_i, hilo_mf_i, a_i, b_i, prod_i,
    input  stall_o, div_done_o, hilo_rdata_o, hi_o, lo_o
  );

  modport slave (
    input  flush, div_i, hassign_i, hilo_en_i, hilo_mf_i, a_i, b_i, prod_i,
    output stall_o, div_done_o, hilo_rdata_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_div_unit.sv
// rtl/hilo_div_unit.sv - HI/LO register pair with MULT/MTHI/MTLO writes and radix-2 restoring divider
// Purpose: owns HI/LO, commits multiplier products and move-to writes, serves MFHI/MFLO,
//          and runs DIV/DIVU one quotient bit per cycle while stalling the pipeline.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : hilo_div_unit_if.slave (controls, operands, stall/done, HI/LO data)
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  hilo_div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] raw_a;
  logic             q_neg, r_neg, b_zero;

  logic             stall, done;
  logic             start, wr_en, commit;

  // Operand conditioning for the start cycle
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign a_neg = bus.hassign_i & bus.a_i[WIDTH-1];
  assign b_neg = bus.hassign_i & bus.b_i[WIDTH-1];
  assign a_abs = a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
  assign b_abs = b_neg ? (~bus.b_i + 1'b1) : bus.b_i;

  assign start  = (state == IDLE) && bus.div_i && !bus.flush;
  assign wr_en  = (state == IDLE) && !bus.div_i && !bus.flush;
  assign commit = (state == DONE) && !bus.flush;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor if it fits. quo doubles as the dividend shift register.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             take;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             unused_sub_msb;

  assign rem_shift      = {rem, quo[WIDTH-1]};
  assign rem_sub        = rem_shift - {1'b0, divisor};
  assign take           = (rem_shift >= {1'b0, divisor});
  // Remainder after a successful subtract is below the divisor, so the MSB is always 0
  assign rem_nxt        = take ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_nxt        = {quo[WIDTH-2:0], take};
  assign unused_sub_msb = rem_sub[WIDTH];

  // Final signed fix-up; divide-by-zero overrides with all-ones / raw dividend
  logic [WIDTH-1:0] lo_div, hi_div;

  assign lo_div = b_zero ? {WIDTH{1'b1}} : (q_neg ? (~quo + 1'b1) : quo);
  assign hi_div = b_zero ? raw_a         : (r_neg ? (~rem + 1'b1) : rem);

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
          if (count == CW'(WIDTH - 1)) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        done      = !bus.flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate with rst so the pipeline is never frozen while the unit is held in reset
  assign bus.stall_o    = stall & rst;
  assign bus.div_done_o = done & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (start)              count <= '0;
      else if (state == BUSY) count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      raw_a   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      b_zero  <= 1'b0;
    end else if (start) begin
      divisor <= b_abs;
      quo     <= a_abs;
      rem     <= '0;
      raw_a   <= bus.a_i;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
      b_zero  <= (bus.b_i == '0);
    end else if (state == BUSY) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= hi_div;
      lo <= lo_div;
    end else if (wr_en) begin
      case (bus.hilo_en_i)
        2'b01: begin
          hi <= bus.prod_i[2*WIDTH-1:WIDTH];
          lo <= bus.prod_i[WIDTH-1:0];
        end
        2'b11:   hi <= bus.a_i;
        2'b10:   lo <= bus.a_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus.hilo_mf_i)
      2'b01:   bus.hilo_rdata_o = hi;
      2'b00:   bus.hilo_rdata_o = lo;
      default: bus.hilo_rdata_o = '0;
    endcase
  end

  assign bus.hi_o = hi;
  assign bus.lo_o = lo;

endmodule

// File: tb/tb_hilo_div_unit.sv
// tb/tb_hilo_div_unit.sv - scoreboard bench for hilo_div_unit
module tb_hilo_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hilo_div_unit_if #(.WIDTH(W)) bus();

  hilo_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks    = 0;
  int   errors    = 0;
  int   done_seen = 0;
  int   run       = 0;
  int   done_run  = 0;
  bit   pend      = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: measures the stall run of each divide and compares HI/LO the cycle after div_done_o
  always @(negedge clk) begin
    if (!rst) begin
      run  = 0;
      pend = 0;
    end else begin
      if (pend) begin
        pend = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL div_unexpected: got div_done_o with no divide outstanding");
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_lo"}, bus.lo_o, e.lo);
          chk({e.name, "_hi"}, bus.hi_o, e.hi);
          chk({e.name, "_stall_cycles"}, 32'(done_run), 32'(W + 1));
        end
      end
      if (bus.div_done_o) begin
        done_seen++;
        done_run = run;
        run      = 0;
        pend     = 1;
      end else if (bus.stall_o) begin
        run++;
      end else begin
        run = 0;
      end
    end
  end

  // Issues a divide and holds div_i like the pipeline would until the DONE cycle passes
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input string name);
    exp_t x;
    int   n;
    x.hi = exp_hi;
    x.lo = exp_lo;
    x.name = name;
    exp_q.push_back(x);
    bus.a_i       = a;
    bus.b_i       = b;
    bus.hassign_i = sgn;
    bus.div_i     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.div_done_o && n < 100);
    if (!bus.div_done_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no div_done_o after %0d cycles, required within %0d", name, n, W + 2);
      void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
    bus.div_i     = 1'b0;
    bus.hassign_i = 1'b0;
  endtask

  int d0;

  initial begin
    bus.flush     = 1'b0;
    bus.div_i     = 1'b1;
    bus.hassign_i = 1'b0;
    bus.hilo_en_i = 2'b01;
    bus.hilo_mf_i = 2'b10;
    bus.a_i       = 32'd5;
    bus.b_i       = 32'd1;
    bus.prod_i    = 64'hDEAD_BEEF_CAFE_F00D;

    // Reset with a divide and a write requested: nothing may happen
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hi", bus.hi_o, 32'h0);
    chk("reset_lo", bus.lo_o, 32'h0);
    chk("reset_stall", {31'b0, bus.stall_o}, 32'h0);
    chk("reset_done", {31'b0, bus.div_done_o}, 32'h0);
    bus.div_i     = 1'b0;
    bus.hilo_en_i = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, "div_ovf");
    run_div(32'h0000_1234, 32'h0, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0");

    // MULT then MFHI; same-cycle read returns the old HI
    bus.prod_i    = 64'h0000_0001_FFFF_FFFE;
    bus.hilo_en_i = 2'b01;
    bus.hilo_mf_i = 2'b01;
    @(negedge clk);
    chk("mult_same_cycle_read", bus.hilo_rdata_o, 32'h0000_1234);
    @(posedge clk);
    #1;
    bus.hilo_en_i = 2'b00;
    @(negedge clk);
    chk("mfhi_after_mult", bus.hilo_rdata_o, 32'h1);
    chk("lo_after_mult", bus.lo_o, 32'hFFFF_FFFE);

    // MTLO then MFLO
    @(posedge clk);
    #1;
    bus.hilo_en_i = 2'b10;
    bus.a_i       = 32'hA5A5_A5A5;
    bus.hilo_mf_i = 2'b00;
    @(negedge clk);
    chk("mtlo_same_cycle_read", bus.hilo_rdata_o, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    bus.hilo_en_i = 2'b00;
    @(negedge clk);
    chk("mflo_after_mtlo", bus.hilo_rdata_o, 32'hA5A5_A5A5);
    chk("hi_kept_after_mtlo", bus.hi_o, 32'h1);
    bus.hilo_mf_i = 2'b10;
    #1;
    chk("mf_none_zero", bus.hilo_rdata_o, 32'h0);
    bus.hilo_mf_i = 2'b11;
    #1;
    chk("mf_11_zero", bus.hilo_rdata_o, 32'h0);

    // Flush in IDLE suppresses an MTHI
    @(posedge clk);
    #1;
    bus.hilo_en_i = 2'b11;
    bus.a_i       = 32'h0000_DEAD;
    bus.flush     = 1'b1;
    @(posedge clk);
    #1;
    bus.hilo_en_i = 2'b00;
    bus.flush     = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_mthi", bus.hi_o, 32'h1);

    // Flush in BUSY cycle 10
    @(posedge clk);
    #1;
    d0            = done_seen;
    bus.a_i       = 32'd50;
    bus.b_i       = 32'hFFFF_FFFD;
    bus.hassign_i = 1'b1;
    bus.div_i     = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_stall", {31'b0, bus.stall_o}, 32'h0);
    chk("flush_busy_done", {31'b0, bus.div_done_o}, 32'h0);
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.div_i     = 1'b0;
    bus.hassign_i = 1'b0;
    @(negedge clk);
    chk("flush_after_stall", {31'b0, bus.stall_o}, 32'h0);
    chk("flush_hi_kept", bus.hi_o, 32'h1);
    chk("flush_lo_kept", bus.lo_o, 32'hA5A5_A5A5);
    chk("flush_no_done_pulse", 32'(done_seen), 32'(d0));
    @(posedge clk);
    #1;
    run_div(32'd1000, 32'd10, 1'b0, 32'd0, 32'd100, "divu_after_flush");

    // Preload, then reset in the middle of a divide
    bus.prod_i    = 64'h0000_0011_0000_0022;
    bus.hilo_en_i = 2'b01;
    @(posedge clk);
    #1;
    bus.hilo_en_i = 2'b00;
    @(negedge clk);
    chk("preload_hi", bus.hi_o, 32'h11);
    chk("preload_lo", bus.lo_o, 32'h22);
    @(posedge clk);
    #1;
    bus.a_i       = 32'd77;
    bus.b_i       = 32'd5;
    bus.hassign_i = 1'b1;
    bus.div_i     = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midreset_hi", bus.hi_o, 32'h0);
    chk("midreset_lo", bus.lo_o, 32'h0);
    chk("midreset_stall", {31'b0, bus.stall_o}, 32'h0);
    bus.div_i     = 1'b0;
    bus.hassign_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, "divu_9_3");

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Execute-stage consumer of the ALU decoder's `div`, `hassign`, `hilo_en` and `hilo_mf` controls.
- Owns the HI/LO register pair, performs MULT/MULTU and MTHI/MTLO writes, and serves MFHI/MFLO reads.
- Contains a radix-2 restoring divider for DIV/DIVU that stalls the pipeline until the result is written to HI/LO.

Parameters:
- WIDTH, 32, operand width; the divider runs one quotient bit per cycle.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- flush  input  1  cancel the current E-stage instruction and any divide in progress
- div_i  input  1  start/hold divide (decoder `div`), held by pipeline while stall_o=1
- hassign_i  input  1  1 = signed divide (decoder `hassign`)
- hilo_en_i  input  2  00 none, 01 write HI and LO from prod_i, 11 write HI from a_i, 10 write LO from a_i
- hilo_mf_i  input  2  01 read HI, 00 read LO, 10 no read
- a_i  input  WIDTH  rs operand (dividend / MTHI / MTLO data)
- b_i  input  WIDTH  rt operand (divisor)
- prod_i  input  2*WIDTH  multiplier product {hi, lo}
- stall_o  output  1  freeze IF/ID/E while the divide is pending
- div_done_o  output  1  one-cycle pulse when the divide result is committed
- hilo_rdata_o  output  WIDTH  HI or LO per hilo_mf_i; 0 when hilo_mf_i = 10 or 11
- hi_o  output  WIDTH  current HI
- lo_o  output  WIDTH  current LO

Behaviour:
- Reset (rst=0, asynchronous): HI=0, LO=0, state=IDLE, counter=0, div_done_o=0. stall_o=0 while reset is asserted.
- FSM states: IDLE, BUSY, DONE.
- IDLE with div_i=1 and flush=0:
  - stall_o=1 (combinational).
  - Latch |a|, |b|, the quotient sign (a[MSB]^b[MSB] when signed), the remainder sign (a[MSB] when signed), raw a_i, and a b_i==0 flag.
  - Next state BUSY, counter=0.
- BUSY: stall_o=1; one restoring step per cycle; counter increments; after WIDTH cycles, next state DONE.
- DONE: stall_o=0, div_done_o=1. On this clock edge:
  - LO=quotient, HI=remainder.
  - Signed: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Next state IDLE; the pipeline advances on the same edge.
- Latency: stall_o is high for exactly WIDTH+1 cycles, then DONE lasts 1 cycle. The divide occupies E for WIDTH+2 cycles.
- Divide by zero (b==0): LO = all ones, HI = raw a_i, regardless of hassign. Timing is identical to a normal divide.
- Signed overflow (-2^(WIDTH-1) / -1): LO = 0x80000000, HI = 0. No trap.
- hilo_en writes:
  - Committed on the clock edge when state=IDLE, div_i=0, flush=0.
  - 01: HI=prod_i[2W-1:W], LO=prod_i[W-1:0]. 11: HI=a_i. 10: LO=a_i.
  - If div_i=1 and hilo_en_i≠00 simultaneously, hilo_en_i is ignored and the divide wins.
- Reads: hilo_rdata_o is combinational from the registered HI/LO.
  - The write occurs at the end of E, so an MFHI in the next cycle sees the new value; no bypass is required.
  - A read issued in the same cycle as a write returns the old value.
- flush:
  - In BUSY or DONE: abort to IDLE, no HI/LO write, no div_done_o, stall_o=0 that cycle.
  - In IDLE: suppresses both the divide start and any hilo_en write.
- Reset mid-divide: immediate return to IDLE with HI=LO=0; the partial result is discarded.
- Back-to-back divides: a new div_i is accepted in the cycle after DONE (state IDLE). The state is never re-entered from DONE on the same instruction.

Test Plan:
- DIVU a=100, b=7, div_i held per stall_o -> stall_o high 33 cycles, div_done_o pulse on cycle 34, then LO=14, HI=2.
- DIV signed a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 -> after 33 stall cycles, LO=0xFFFFFFFF, HI=0x1234.
- MULT with prod_i=0x00000001_FFFFFFFE and hilo_en=01; next cycle MFHI -> hilo_rdata_o=1. Then MTLO a_i=0xA5A5A5A5; next MFLO -> 0xA5A5A5A5, and HI is unchanged.
- DIV started, flush asserted in BUSY cycle 10 -> stall_o drops that cycle, no div_done_o, HI/LO retain their prior values. A new DIVU issued next cycle completes normally.
- HI/LO preloaded to nonzero, DIV started, rst driven low at BUSY cycle 5 -> HI=LO=0, stall_o=0 immediately. After release, a new DIVU 9/3 gives LO=3, HI=0.
